// File: rtl/usr_pkg.sv
// usr_pkg: opcodes, FSM states and move decode for usr_shift_engine (USR_ROTATE_EN enables ROR/ROL)
package usr_pkg;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_SHR   = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_CLEAR = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ROL   = 3'b110;

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    // Opcodes that move one bit per cycle and therefore honour cmd_amt
    function automatic logic op_moves(input logic [2:0] op);
`ifdef USR_ROTATE_EN
        return op inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL};
`else
        return op inside {OP_SHR, OP_SHL};
`endif
    endfunction

endpackage

// File: rtl/usr_shift_datapath.sv
// usr_shift_datapath: next register/serial-out value for one opcode step (USR_ROTATE_EN enables ROR/ROL)
module usr_shift_datapath
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] pi,
    input  logic [WIDTH-1:0] po,
    input  logic             so,
    input  logic             si,
    output logic [WIDTH-1:0] po_nxt,
    output logic             so_nxt
);

    // One step of the selected operation; unknown or disabled opcodes hold
    always_comb begin
        po_nxt = po;
        so_nxt = so;
        case (op)
            OP_SHR:   begin po_nxt = {si, po[WIDTH-1:1]};        so_nxt = po[0];       end
            OP_SHL:   begin po_nxt = {po[WIDTH-2:0], si};        so_nxt = po[WIDTH-1]; end
            OP_LOAD:  po_nxt = pi;
            OP_CLEAR: po_nxt = '0;
`ifdef USR_ROTATE_EN
            OP_ROR:   begin po_nxt = {po[0], po[WIDTH-1:1]};     so_nxt = po[0];       end
            OP_ROL:   begin po_nxt = {po[WIDTH-2:0], po[WIDTH-1]}; so_nxt = po[WIDTH-1]; end
`endif
            default:  ;
        endcase
    end

endmodule

// File: rtl/usr_shift_engine.sv
// usr_shift_engine: command-driven universal shift register, one bit per cycle (USR_ROTATE_EN enables ROR/ROL)
module usr_shift_engine
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] PI,
    input  logic             SI,
    output logic [WIDTH-1:0] PO,
    output logic             SO,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       op_q, op_q_nxt, dp_op;
    logic [WIDTH-1:0] po_nxt;
    logic             so_nxt, done_nxt;

    assign cmd_ready = state == ST_IDLE;
    assign busy      = state == ST_SHIFT;

    usr_shift_datapath #(.WIDTH(WIDTH)) u_dp (
        .op     (dp_op),
        .pi     (PI),
        .po     (PO),
        .so     (SO),
        .si     (SI),
        .po_nxt (po_nxt),
        .so_nxt (so_nxt)
    );

    // Sequencing: the first bit moves on the accept edge, remaining amt-1 bits in SHIFT
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_q_nxt  = op_q;
        done_nxt  = 1'b0;
        dp_op     = OP_HOLD;
        if (state == ST_SHIFT) begin
            dp_op   = op_q;
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
            end
        end else if (cmd_valid) begin
            dp_op    = (op_moves(cmd_op) && cmd_amt == '0) ? OP_HOLD : cmd_op;
            done_nxt = 1'b1;
            if (op_moves(cmd_op) && cmd_amt >= CNT_W'(2)) begin
                state_nxt = ST_SHIFT;
                cnt_nxt   = cmd_amt - CNT_W'(1);
                op_q_nxt  = cmd_op;
                done_nxt  = 1'b0;
            end
        end
    end

    // State, counter and visible registers; reset aborts any command at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_HOLD;
            PO    <= '0;
            SO    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_q_nxt;
            PO    <= po_nxt;
            SO    <= so_nxt;
            done  <= done_nxt;
        end
    end

endmodule
